// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared door-lock types and default constants
package smart_home_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } door_state_e;

    localparam int DEFAULT_PW  = 45675;
    localparam int MAX_FAIL    = 3;
    localparam int UNLOCK_CYC  = 8;
    localparam int LOCKOUT_CYC = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_door_lock_if.sv
// rtl/multi_door_lock_if.sv - per-door strobes, passwords and status outputs
// master: drives strobes/passwords, observes status (user side)
// slave : the lock controller
interface multi_door_lock_if #(
    parameter int NUM_DOORS = 8,
    parameter int PW_W      = 17
);
    logic [NUM_DOORS-1:0]           e_buttonState;
    logic [NUM_DOORS-1:0]           rs_buttonState;
    logic [NUM_DOORS-1:0]           lock_button;
    logic [NUM_DOORS-1:0][PW_W-1:0] in_password;
    logic [NUM_DOORS-1:0][PW_W-1:0] change_password;
    logic [NUM_DOORS-1:0]           unlock;
    logic [NUM_DOORS-1:0]           burglar_alarm_enable;
    logic [NUM_DOORS-1:0]           pw_changed;
    logic                           any_alarm;

    modport master (
        output e_buttonState, rs_buttonState, lock_button, in_password, change_password,
        input  unlock, burglar_alarm_enable, pw_changed, any_alarm
    );

    modport slave (
        input  e_buttonState, rs_buttonState, lock_button, in_password, change_password,
        output unlock, burglar_alarm_enable, pw_changed, any_alarm
    );
endinterface

// File: rtl/door_lock_fsm.sv
// rtl/door_lock_fsm.sv - one door: LOCKED/UNLOCKED/LOCKOUT with stored password
// Ports: clk, reset_signal (sync active-low); e_button, rs_button, lock_button
// strobes; in_password, change_password; unlock, alarm, pw_changed outputs.
module door_lock_fsm #(
    parameter int            PW_W        = 17,
    parameter logic [PW_W-1:0] DEFAULT_PW = PW_W'(smart_home_pkg::DEFAULT_PW),
    parameter int            MAX_FAIL    = smart_home_pkg::MAX_FAIL,
    parameter int            UNLOCK_CYC  = smart_home_pkg::UNLOCK_CYC,
    parameter int            LOCKOUT_CYC = smart_home_pkg::LOCKOUT_CYC
) (
    input  logic            clk,
    input  logic            reset_signal,
    input  logic            e_button,
    input  logic            rs_button,
    input  logic            lock_button,
    input  logic [PW_W-1:0] in_password,
    input  logic [PW_W-1:0] change_password,
    output logic            unlock,
    output logic            alarm,
    output logic            pw_changed
);
    import smart_home_pkg::*;

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = $clog2(max_int(UNLOCK_CYC, LOCKOUT_CYC) + 1);

    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  UNLOCK_T   = TMR_W'(UNLOCK_CYC);
    localparam logic [TMR_W-1:0]  LOCKOUT_T  = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);

    door_state_e       state, state_next;
    logic [PW_W-1:0]   stored_pw, stored_pw_next;
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic              pw_changed_q, pw_changed_next;

    logic              pw_match;
    logic [FAIL_W-1:0] fail_inc;

    assign pw_match = (in_password == stored_pw);
    // fail_cnt stays below FAIL_LIMIT while LOCKED, so the increment never overflows
    assign fail_inc = fail_cnt + FAIL_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_signal) begin
            state        <= LOCKED;
            stored_pw    <= DEFAULT_PW;
            fail_cnt     <= '0;
            timer        <= '0;
            pw_changed_q <= 1'b0;
        end else begin
            state        <= state_next;
            stored_pw    <= stored_pw_next;
            fail_cnt     <= fail_cnt_next;
            timer        <= timer_next;
            pw_changed_q <= pw_changed_next;
        end
    end

    always_comb begin
        state_next      = state;
        stored_pw_next  = stored_pw;
        fail_cnt_next   = fail_cnt;
        timer_next      = timer;
        pw_changed_next = 1'b0;
        case (state)
            LOCKED: begin
                // rs_button is deliberately not looked at here
                if (e_button) begin
                    if (pw_match) begin
                        state_next    = UNLOCKED;
                        fail_cnt_next = '0;
                        timer_next    = UNLOCK_T;
                    end else if (fail_inc >= FAIL_LIMIT) begin
                        state_next    = LOCKOUT;
                        fail_cnt_next = FAIL_LIMIT;
                        timer_next    = LOCKOUT_T;
                    end else begin
                        fail_cnt_next = fail_inc;
                    end
                end
            end
            UNLOCKED: begin
                if (lock_button) begin
                    state_next = LOCKED;
                    timer_next = '0;
                end else if (rs_button && pw_match) begin
                    stored_pw_next  = change_password;
                    pw_changed_next = 1'b1;
                    timer_next      = UNLOCK_T;
                end else if (timer <= TMR_ONE) begin
                    // leaving on the decrement to zero keeps the door open exactly UNLOCK_CYC cycles
                    state_next = LOCKED;
                    timer_next = '0;
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            LOCKOUT: begin
                if (timer <= TMR_ONE) begin
                    state_next    = LOCKED;
                    fail_cnt_next = '0;
                    timer_next    = '0;
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            default: state_next = LOCKED;
        endcase
    end

    always_comb begin
        unlock     = (state == UNLOCKED);
        alarm      = (state == LOCKOUT);
        pw_changed = pw_changed_q;
    end

endmodule

// File: rtl/multi_door_lock.sv
// rtl/multi_door_lock.sv - NUM_DOORS independent door locks plus a global alarm
// Ports: clk; reset_signal (sync active-low); bus (slave) carrying per-door
// strobes/passwords in and unlock, burglar_alarm_enable, pw_changed, any_alarm out.
module multi_door_lock #(
    parameter int              NUM_DOORS   = 8,
    parameter int              PW_W        = 17,
    parameter logic [PW_W-1:0] DEFAULT_PW  = PW_W'(smart_home_pkg::DEFAULT_PW),
    parameter int              MAX_FAIL    = smart_home_pkg::MAX_FAIL,
    parameter int              UNLOCK_CYC  = smart_home_pkg::UNLOCK_CYC,
    parameter int              LOCKOUT_CYC = smart_home_pkg::LOCKOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_signal,
    multi_door_lock_if.slave  bus
);
    import smart_home_pkg::*;

    logic [NUM_DOORS-1:0] unlock_v;
    logic [NUM_DOORS-1:0] alarm_v;
    logic [NUM_DOORS-1:0] pw_changed_v;
    logic                 any_alarm_q;

    for (genvar i = 0; i < NUM_DOORS; i++) begin : g_door
        door_lock_fsm #(
            .PW_W        (PW_W),
            .DEFAULT_PW  (DEFAULT_PW),
            .MAX_FAIL    (MAX_FAIL),
            .UNLOCK_CYC  (UNLOCK_CYC),
            .LOCKOUT_CYC (LOCKOUT_CYC)
        ) u_door (
            .clk             (clk),
            .reset_signal    (reset_signal),
            .e_button        (bus.e_buttonState[i]),
            .rs_button       (bus.rs_buttonState[i]),
            .lock_button     (bus.lock_button[i]),
            .in_password     (bus.in_password[i]),
            .change_password (bus.change_password[i]),
            .unlock          (unlock_v[i]),
            .alarm           (alarm_v[i]),
            .pw_changed      (pw_changed_v[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_signal) begin
            any_alarm_q <= 1'b0;
        end else begin
            any_alarm_q <= |alarm_v;
        end
    end

    assign bus.unlock               = unlock_v;
    assign bus.burglar_alarm_enable = alarm_v;
    assign bus.pw_changed           = pw_changed_v;
    assign bus.any_alarm            = any_alarm_q;

endmodule
